// File: rtl/biquad_seq_ctrl.sv
// biquad_seq_ctrl
//   Sequencer/configurator for one biquad IIR section. Accepts input samples on
//   a valid/ready stream, issues single-cycle bq_valid strobes with a
//   programmable minimum spacing (for multicycle multipliers), captures bq_yout
//   into an output stream and holds double-buffered coefficients behind a
//   simple write port.
//
// Optional feature: define BQ_CFG_READBACK_EN to add the cfg_rdata port
//   (combinational readback of shadow coefficients, div and {busy, enable}).
//   Without it the configuration port is write-only.
//
// Ports
//   clk, nreset            clock, asynchronous active-low reset
//   cfg_we/addr/wdata      config write: 0=b10 1=b11 2=b12 3=a11 4=a12 5=div
//                          6=ctrl (bit0 = enable) 7=ignored
//   cfg_commit, cfg_busy   request/pending shadow->active coefficient copy
//   cfg_rdata              (BQ_CFG_READBACK_EN only) config readback
//   s_valid/s_data/s_ready input sample stream
//   m_valid/m_data/m_ready output sample stream
//   bq_enable, bq_valid,   biquad control, strobe and held input sample
//   bq_x
//   bq_b10..bq_a12         active coefficients
//   bq_yout                biquad output
//
// state   | meaning
// --------+-------------------------------------------------------
// IDLE    | waiting for an accepted sample; commits land here
// STROBE  | bq_valid high for exactly this cycle
// CAPTURE | bq_yout sampled into m_data at the end of this cycle

module biquad_seq_ctrl #(
  parameter int DATAWIDTH = 16,
  parameter int COEFWIDTH = 16,
  parameter int DIVW      = 4,
  parameter int FILL      = 3
) (
  input  logic                 clk,
  input  logic                 nreset,
  input  logic                 cfg_we,
  input  logic [2:0]           cfg_addr,
  input  logic [COEFWIDTH-1:0] cfg_wdata,
  input  logic                 cfg_commit,
  output logic                 cfg_busy,
`ifdef BQ_CFG_READBACK_EN
  output logic [COEFWIDTH-1:0] cfg_rdata,
`endif
  input  logic                 s_valid,
  input  logic [DATAWIDTH-1:0] s_data,
  output logic                 s_ready,
  output logic                 m_valid,
  output logic [COEFWIDTH-1:0] m_data,
  input  logic                 m_ready,
  output logic                 bq_enable,
  output logic                 bq_valid,
  output logic [DATAWIDTH-1:0] bq_x,
  output logic [COEFWIDTH-1:0] bq_b10,
  output logic [COEFWIDTH-1:0] bq_b11,
  output logic [COEFWIDTH-1:0] bq_b12,
  output logic [COEFWIDTH-1:0] bq_a11,
  output logic [COEFWIDTH-1:0] bq_a12,
  input  logic [COEFWIDTH-1:0] bq_yout
);

  localparam int FILLW = (FILL < 1) ? 1 : $clog2(FILL + 1);
  localparam logic [FILLW-1:0] FILL_MAX = FILLW'(FILL);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_STROBE  = 2'd1,
    ST_CAPTURE = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [4:0][COEFWIDTH-1:0] shadow_q;
  logic [4:0][COEFWIDTH-1:0] active_q;
  logic [DIVW-1:0]           div_q;
  logic [DIVW-1:0]           space_q;
  logic [FILLW-1:0]          fill_q;
  logic                      enable_q;
  logic                      busy_q;
  logic                      m_valid_q;
  logic [COEFWIDTH-1:0]      m_data_q;
  logic [DATAWIDTH-1:0]      bq_x_q;

  logic accept;
  logic copy;

  assign s_ready = enable_q & (state_q == ST_IDLE) & (space_q == '0) & ~m_valid_q & ~busy_q;
  assign accept  = s_valid & s_ready;
  // busy already blocks s_ready, so a pending commit always beats an accept.
  assign copy    = busy_q & (state_q == ST_IDLE) & ~accept;

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    bq_valid = 1'b0;
    case (state_q)
      ST_IDLE:    if (accept) state_d = ST_STROBE;
      ST_STROBE: begin
        bq_valid = 1'b1;
        state_d  = ST_CAPTURE;
      end
      ST_CAPTURE: state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // Datapath and configuration registers.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      shadow_q  <= '0;
      active_q  <= '0;
      div_q     <= '0;
      space_q   <= '0;
      fill_q    <= '0;
      enable_q  <= 1'b0;
      busy_q    <= 1'b0;
      m_valid_q <= 1'b0;
      m_data_q  <= '0;
      bq_x_q    <= '0;
    end else begin
      if (accept) bq_x_q <= s_data;

      // Loaded as the strobe begins so pulses are div+1 cycles apart.
      if (accept)              space_q <= div_q;
      else if (space_q != '0)  space_q <= space_q - 1'b1;

      if (m_valid_q && m_ready) m_valid_q <= 1'b0;

      // Fill count is checked before it is bumped, so the first FILL
      // results after reset are dropped.
      if (state_q == ST_CAPTURE) begin
        if (fill_q >= FILL_MAX) begin
          m_valid_q <= 1'b1;
          m_data_q  <= bq_yout;
        end else begin
          fill_q <= fill_q + 1'b1;
        end
      end

      if (copy) begin
        active_q <= shadow_q;
        busy_q   <= 1'b0;
      end else if (cfg_commit) begin
        busy_q <= 1'b1;
      end

      if (cfg_we) begin
        case (cfg_addr)
          3'd0:    shadow_q[0] <= cfg_wdata;
          3'd1:    shadow_q[1] <= cfg_wdata;
          3'd2:    shadow_q[2] <= cfg_wdata;
          3'd3:    shadow_q[3] <= cfg_wdata;
          3'd4:    shadow_q[4] <= cfg_wdata;
          3'd5:    div_q       <= cfg_wdata[DIVW-1:0];
          3'd6:    enable_q    <= cfg_wdata[0];
          default: ;
        endcase
      end
    end
  end

`ifdef BQ_CFG_READBACK_EN
  always_comb begin
    cfg_rdata = '0;
    case (cfg_addr)
      3'd0:    cfg_rdata = shadow_q[0];
      3'd1:    cfg_rdata = shadow_q[1];
      3'd2:    cfg_rdata = shadow_q[2];
      3'd3:    cfg_rdata = shadow_q[3];
      3'd4:    cfg_rdata = shadow_q[4];
      3'd5:    cfg_rdata = COEFWIDTH'(div_q);
      3'd6:    cfg_rdata = COEFWIDTH'({busy_q, enable_q});
      default: cfg_rdata = '0;
    endcase
  end
`endif

  assign cfg_busy  = busy_q;
  assign m_valid   = m_valid_q;
  assign m_data    = m_data_q;
  assign bq_enable = enable_q;
  assign bq_x      = bq_x_q;
  assign bq_b10    = active_q[0];
  assign bq_b11    = active_q[1];
  assign bq_b12    = active_q[2];
  assign bq_a11    = active_q[3];
  assign bq_a12    = active_q[4];

endmodule

// File: tb/tb_biquad_seq_ctrl.sv
// Testbench for biquad_seq_ctrl: configuration vector table, hand-written
// streaming corner cases, and a randomized run against a timestamp-based
// reference model.

module tb_biquad_seq_ctrl;

  logic        clk = 1'b0;
  logic        nreset;
  logic        cfg_we;
  logic [2:0]  cfg_addr;
  logic [15:0] cfg_wdata;
  logic        cfg_commit;
  logic        cfg_busy;
`ifdef BQ_CFG_READBACK_EN
  logic [15:0] cfg_rdata;
`endif
  logic        s_valid;
  logic [15:0] s_data;
  logic        s_ready;
  logic        m_valid;
  logic [15:0] m_data;
  logic        m_ready;
  logic        bq_enable;
  logic        bq_valid;
  logic [15:0] bq_x;
  logic [15:0] bq_b10, bq_b11, bq_b12, bq_a11, bq_a12;
  logic [15:0] bq_yout;

  biquad_seq_ctrl dut (
    .clk(clk), .nreset(nreset),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
    .cfg_commit(cfg_commit), .cfg_busy(cfg_busy),
`ifdef BQ_CFG_READBACK_EN
    .cfg_rdata(cfg_rdata),
`endif
    .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
    .m_valid(m_valid), .m_data(m_data), .m_ready(m_ready),
    .bq_enable(bq_enable), .bq_valid(bq_valid), .bq_x(bq_x),
    .bq_b10(bq_b10), .bq_b11(bq_b11), .bq_b12(bq_b12),
    .bq_a11(bq_a11), .bq_a12(bq_a12), .bq_yout(bq_yout)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: the pipeline is described by the cycle index of the last
  // accept; strobe, capture and idle follow from the age of that accept.
  int          cyc, last_acc, div_acc;
  bit          m_en, m_busy, m_mv;
  int          m_div, m_fill;
  logic [15:0] m_sh [5];
  logic [15:0] m_act[5];
  logic [15:0] m_md, m_bqx;

  task automatic model_reset();
    cyc = 0; last_acc = -1000; div_acc = 0;
    m_en = 0; m_busy = 0; m_mv = 0; m_div = 0; m_fill = 0;
    m_md = 0; m_bqx = 0;
    for (int i = 0; i < 5; i++) begin m_sh[i] = 0; m_act[i] = 0; end
  endtask

  function automatic bit exp_ready();
    int age;
    age = cyc - last_acc;
    return m_en && (age >= 3) && (age >= div_acc + 1) && !m_mv && !m_busy;
  endfunction

  task automatic model_edge();
    int age;
    bit acc, copy;
    age  = cyc - last_acc;
    acc  = s_valid && exp_ready();
    copy = m_busy && (age >= 3);
    if (m_mv && m_ready) m_mv = 0;
    if (age == 2) begin
      if (m_fill >= 3) begin m_mv = 1; m_md = bq_yout; end
      else m_fill++;
    end
    if (acc) begin last_acc = cyc; div_acc = m_div; m_bqx = s_data; end
    if (copy) begin
      for (int i = 0; i < 5; i++) m_act[i] = m_sh[i];
      m_busy = 0;
    end else if (cfg_commit) m_busy = 1;
    if (cfg_we) begin
      if (cfg_addr < 5)       m_sh[cfg_addr] = cfg_wdata;
      else if (cfg_addr == 5) m_div = int'(cfg_wdata[3:0]);
      else if (cfg_addr == 6) m_en = cfg_wdata[0];
    end
    cyc++;
  endtask

  task automatic check_outputs();
    chk("bq_valid", bq_valid, (cyc - last_acc) == 1);
    chk("bq_x", bq_x, m_bqx);
    chk("m_valid", m_valid, m_mv);
    if (m_mv) chk("m_data", m_data, m_md);
    chk("cfg_busy", cfg_busy, m_busy);
    chk("bq_enable", bq_enable, m_en);
    chk("bq_b10", bq_b10, m_act[0]);
    chk("bq_b11", bq_b11, m_act[1]);
    chk("bq_b12", bq_b12, m_act[2]);
    chk("bq_a11", bq_a11, m_act[3]);
    chk("bq_a12", bq_a12, m_act[4]);
`ifdef BQ_CFG_READBACK_EN
    begin
      logic [15:0] e;
      if (cfg_addr < 5)       e = m_sh[cfg_addr];
      else if (cfg_addr == 5) e = 16'(m_div);
      else if (cfg_addr == 6) e = {14'd0, m_busy, m_en};
      else                    e = 16'd0;
      chk("cfg_rdata", cfg_rdata, e);
    end
`endif
  endtask

  // One clock: inputs are already applied; check s_ready, advance the model,
  // then compare registered outputs away from the active edge.
  task automatic tick();
    chk("s_ready", s_ready, exp_ready());
    model_edge();
    @(negedge clk);
    check_outputs();
    s_data  = 16'($urandom);
    bq_yout = 16'($urandom);
  endtask

  task automatic do_reset();
    cfg_we = 0; cfg_addr = 0; cfg_wdata = 0; cfg_commit = 0;
    s_valid = 0; s_data = 0; m_ready = 0; bq_yout = 0;
    nreset = 0;
    model_reset();
    #1;
    check_outputs();
    chk("rst_s_ready", s_ready, 0);
    @(negedge clk);
    @(negedge clk);
    nreset = 1;
  endtask

  task automatic cfg_write(input logic [2:0] a, input logic [15:0] d);
    cfg_we = 1; cfg_addr = a; cfg_wdata = d;
    tick();
    cfg_we = 0;
  endtask

  typedef struct {
    logic        we;
    logic [2:0]  addr;
    logic [15:0] wdata;
    logic        commit;
    logic        exp_busy;
    logic [15:0] exp_b10;
    logic [15:0] exp_a11;
  } cfg_vec_t;

  cfg_vec_t vecs[12];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int w, k, first_mv, c_mv, c_rdy, c_bv;
    int st[$];
    logic [15:0] md;
    logic [15:0] a11_h[$];
    bit v_h[$];

    vecs[0]  = '{1, 3'd0, 16'h4000, 0, 0, 16'h0000, 16'h0000};
    vecs[1]  = '{0, 3'd0, 16'h0000, 0, 0, 16'h0000, 16'h0000};
    vecs[2]  = '{0, 3'd0, 16'h0000, 1, 1, 16'h0000, 16'h0000};
    vecs[3]  = '{0, 3'd0, 16'h0000, 0, 0, 16'h4000, 16'h0000};
    vecs[4]  = '{1, 3'd3, 16'hC000, 1, 1, 16'h4000, 16'h0000};
    vecs[5]  = '{1, 3'd3, 16'h1234, 0, 0, 16'h4000, 16'hC000};
    vecs[6]  = '{0, 3'd0, 16'h0000, 1, 1, 16'h4000, 16'hC000};
    vecs[7]  = '{0, 3'd0, 16'h0000, 0, 0, 16'h4000, 16'h1234};
    vecs[8]  = '{1, 3'd7, 16'hFFFF, 0, 0, 16'h4000, 16'h1234};
    vecs[9]  = '{1, 3'd0, 16'h0001, 0, 0, 16'h4000, 16'h1234};
    vecs[10] = '{0, 3'd0, 16'h0000, 1, 1, 16'h4000, 16'h1234};
    vecs[11] = '{0, 3'd0, 16'h0000, 1, 0, 16'h0001, 16'h1234};

    // Reset, then outputs stay quiet while disabled.
    do_reset();
    for (int i = 0; i < 3; i++) tick();

    // Configuration table.
    for (int i = 0; i < 12; i++) begin
      cfg_we = vecs[i].we; cfg_addr = vecs[i].addr;
      cfg_wdata = vecs[i].wdata; cfg_commit = vecs[i].commit;
      tick();
      chk($sformatf("vec%0d_busy", i), cfg_busy, vecs[i].exp_busy);
      chk($sformatf("vec%0d_b10", i), bq_b10, vecs[i].exp_b10);
      chk($sformatf("vec%0d_a11", i), bq_a11, vecs[i].exp_a11);
    end
    cfg_we = 0; cfg_commit = 0;

    // div=5, continuous input: strobes 6 clk apart, 4th result is first out.
    do_reset();
    cfg_write(3'd5, 16'd5);
    cfg_write(3'd6, 16'd1);
    s_valid = 1; m_ready = 1;
    k = 0; first_mv = -1;
    for (int i = 0; i < 40; i++) begin
      tick(); k++;
      if (bq_valid) st.push_back(k);
      if (m_valid && first_mv < 0) first_mv = k;
    end
    chk("t3_nstrobe_ge5", st.size() >= 5, 1);
    for (int j = 1; j < st.size(); j++) chk("t3_spacing", st[j] - st[j-1], 6);
    if (st.size() >= 4) chk("t3_first_mvalid", first_mv, st[3] + 2);

    // Back-pressure: m_valid held with m_ready low.
    m_ready = 0;
    w = 0;
    while (!m_valid && w < 20) begin tick(); w++; end
    chk("t4_mvalid_seen", m_valid, 1);
    md = m_data;
    for (int i = 0; i < 20; i++) begin
      chk("t4_no_ready", s_ready, 0);
      tick();
      chk("t4_no_strobe", bq_valid, 0);
      chk("t4_m_data_hold", m_data, md);
    end
    m_ready = 1;
    tick();
    w = 0;
    while (!bq_valid && w < 10) begin tick(); w++; end
    chk("t4_resume", bq_valid, 1);

    // Commit a11 while streaming at div=0.
    cfg_write(3'd5, 16'd0);
    cfg_write(3'd3, 16'hC000);
    cfg_commit = 1; tick(); cfg_commit = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      a11_h.push_back(bq_a11);
      v_h.push_back(bq_valid);
    end
    for (int j = 1; j + 1 < a11_h.size(); j++) begin
      if (v_h[j]) begin
        chk("t5_a11_at_strobe", a11_h[j], a11_h[j-1]);
        chk("t5_a11_at_capture", a11_h[j+1], a11_h[j]);
      end
    end
    chk("t5_a11_final", bq_a11, 16'hC000);

    // Disable during STROBE: capture still delivered, no new accepts.
    w = 0;
    while (!bq_valid && w < 10) begin tick(); w++; end
    chk("t6_strobe_seen", bq_valid, 1);
    cfg_write(3'd6, 16'd0);
    c_mv = 0; c_rdy = 0; c_bv = 0;
    for (int i = 0; i < 8; i++) begin
      if (s_ready) c_rdy++;
      tick();
      if (m_valid) c_mv++;
      if (bq_valid) c_bv++;
    end
    chk("t6_mvalid_delivered", c_mv, 1);
    chk("t6_no_ready", c_rdy, 0);
    chk("t6_no_strobe", c_bv, 0);
`ifdef BQ_CFG_READBACK_EN
    cfg_addr = 3'd6; #1;
    chk("t6_rdata_ctrl", cfg_rdata, 16'd0);
`endif

    // Randomized run with a mid-run reset.
    do_reset();
    cfg_write(3'd6, 16'd1);
    for (int i = 0; i < 800; i++) begin
      if (i == 400) begin
        do_reset();
        cfg_write(3'd6, 16'd1);
      end
      cfg_we    = ($urandom_range(0, 7) == 0);
      cfg_addr  = 3'($urandom_range(0, 7));
      cfg_wdata = 16'($urandom);
      if (cfg_addr == 3'd6) cfg_wdata[0] = ($urandom_range(0, 3) != 0);
      if (cfg_addr == 3'd5) cfg_wdata = 16'($urandom_range(0, 6));
      cfg_commit = ($urandom_range(0, 9) == 0);
      s_valid    = ($urandom_range(0, 9) < 7);
      m_ready    = ($urandom_range(0, 9) < 6);
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
